// File: rtl/stream_operand_splitter_pkg.sv
// Shared definitions for the operand splitter: FSM states and lane-index sizing.
package stream_operand_splitter_pkg;

    typedef enum logic {
        FILL = 1'b0,
        PAD  = 1'b1
    } split_state_e;

    function automatic int idx_bits(input int num_channels);
        return (num_channels > 2) ? $clog2(num_channels) : 1;
    endfunction

endpackage

// File: rtl/stream_operand_splitter_if.sv
// Bundles the scalar input stream and the N-lane operand output of the splitter.
// slave is the splitter's view, master is the view of the surrounding logic.
interface stream_operand_splitter_if #(
    parameter int C_DATA_WIDTH   = 256,
    parameter int C_NUM_CHANNELS = 2
) ();
    logic                                         s_tvalid;
    logic [C_DATA_WIDTH-1:0]                      s_tdata;
    logic                                         s_tlast;
    logic                                         s_tready;
    logic [C_NUM_CHANNELS-1:0]                    m_tvalid;
    logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  m_tdata;
    logic                                         m_tlast;
    logic [C_NUM_CHANNELS-1:0]                    m_tready;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/stream_operand_bank.sv
// N-lane output register: loads a whole group at once, retires lanes independently,
// and reports whether it can accept a new group on the coming edge.
module stream_operand_bank #(
    parameter int C_DATA_WIDTH   = 256,
    parameter int C_NUM_CHANNELS = 2
) (
    input  logic                                         aclk,
    input  logic                                         areset,
    input  logic                                         load,
    input  logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  load_data,
    input  logic                                         load_last,
    input  logic [C_NUM_CHANNELS-1:0]                    m_tready,
    output logic [C_NUM_CHANNELS-1:0]                    m_tvalid,
    output logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  m_tdata,
    output logic                                         m_tlast,
    output logic                                         bank_free_now
);
    logic bank_busy;

    // The bank is busy exactly while some lane still holds an unretired operand.
    assign bank_busy     = |m_tvalid;
    assign bank_free_now = !bank_busy || ((m_tvalid & ~m_tready) == '0);

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            m_tvalid <= '0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
        end else if (load) begin
            m_tvalid <= '1;
            m_tdata  <= load_data;
            m_tlast  <= load_last;
        end else begin
            m_tvalid <= m_tvalid & ~m_tready;
        end
    end
endmodule

// File: rtl/stream_operand_splitter.sv
// Deals a stream of field elements round-robin into groups of operand lanes,
// padding short packets with a multiplicative identity so every group is complete.
module stream_operand_splitter
    import stream_operand_splitter_pkg::*;
#(
    parameter int                      C_DATA_WIDTH   = 256,
    parameter int                      C_NUM_CHANNELS = 2,
    parameter logic [C_DATA_WIDTH-1:0] PAD_VALUE      = C_DATA_WIDTH'(1),
    parameter int                      CNT_BITS       = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    stream_operand_splitter_if.slave bus,
    output logic [CNT_BITS-1:0]   o_short_cnt
);
    localparam int                  IDX_BITS = idx_bits(C_NUM_CHANNELS);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(C_NUM_CHANNELS - 1);

    split_state_e                                 state, next_state;
    logic [IDX_BITS-1:0]                          idx;
    logic [C_DATA_WIDTH-1:0]                      staging [C_NUM_CHANNELS-1];
    logic                                         running;
    logic                                         s_ready, accept, load, load_last;
    logic                                         bank_free_now;
    logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  load_data;
    logic [C_NUM_CHANNELS-1:0]                    lane_valid;
    logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  lane_data;
    logic                                         lane_last;

    stream_operand_bank #(
        .C_DATA_WIDTH   (C_DATA_WIDTH),
        .C_NUM_CHANNELS (C_NUM_CHANNELS)
    ) u_bank (
        .aclk          (aclk),
        .areset        (areset),
        .load          (load),
        .load_data     (load_data),
        .load_last     (load_last),
        .m_tready      (bus.m_tready),
        .m_tvalid      (lane_valid),
        .m_tdata       (lane_data),
        .m_tlast       (lane_last),
        .bank_free_now (bank_free_now)
    );

    assign bus.m_tvalid = lane_valid;
    assign bus.m_tdata  = lane_data;
    assign bus.m_tlast  = lane_last;
    assign bus.s_tready = s_ready;

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) state <= FILL;
        else         state <= next_state;
    end

    // In PAD, idx holds the first lane that must be filled with PAD_VALUE.
    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
        for (int i = 0; i < C_NUM_CHANNELS - 1; i++) load_data[i] = staging[i];
        case (state)
            FILL: begin
                s_ready = running && (idx != LAST_IDX || bank_free_now);
                accept  = bus.s_tvalid && s_ready;
                if (accept) begin
                    if (idx == LAST_IDX) begin
                        load                        = 1'b1;
                        load_last                   = bus.s_tlast;
                        load_data[C_NUM_CHANNELS-1] = bus.s_tdata;
                    end else if (bus.s_tlast) begin
                        next_state = PAD;
                    end
                end
            end
            PAD: begin
                for (int i = 0; i < C_NUM_CHANNELS; i++) begin
                    if (i >= int'(idx)) load_data[i] = PAD_VALUE;
                end
                if (bank_free_now) begin
                    load       = 1'b1;
                    load_last  = 1'b1;
                    next_state = FILL;
                end
            end
            default: next_state = FILL;
        endcase
    end

    // running keeps s_tready low until the first edge after reset release.
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            running     <= 1'b0;
            idx         <= '0;
            o_short_cnt <= '0;
            for (int i = 0; i < C_NUM_CHANNELS - 1; i++) staging[i] <= '0;
        end else begin
            running <= 1'b1;
            if (accept) begin
                if (idx == LAST_IDX) begin
                    idx <= '0;
                end else begin
                    for (int i = 0; i < C_NUM_CHANNELS - 1; i++) begin
                        if (int'(idx) == i) staging[i] <= bus.s_tdata;
                    end
                    idx <= idx + 1'b1;
                end
            end else if (state == PAD && load) begin
                idx <= '0;
                if (o_short_cnt != '1) o_short_cnt <= o_short_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stream_operand_splitter.sv
// Directed vector table plus multi-cycle sequences (reset, random backpressure,
// counter saturation) for the two-lane operand splitter.
module tb_stream_operand_splitter;
    localparam int W = 256;
    localparam int N = 2;

    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic [15:0] short_cnt;
    logic [1:0]  short_cnt2;

    always #5 aclk = ~aclk;

    stream_operand_splitter_if #(.C_DATA_WIDTH(W), .C_NUM_CHANNELS(N)) bus ();
    stream_operand_splitter_if #(.C_DATA_WIDTH(W), .C_NUM_CHANNELS(N)) bus2 ();

    stream_operand_splitter #(
        .C_DATA_WIDTH(W), .C_NUM_CHANNELS(N), .PAD_VALUE(W'(1)), .CNT_BITS(16)
    ) dut (.aclk(aclk), .areset(areset), .bus(bus), .o_short_cnt(short_cnt));

    stream_operand_splitter #(
        .C_DATA_WIDTH(W), .C_NUM_CHANNELS(N), .PAD_VALUE(W'(1)), .CNT_BITS(2)
    ) sat_dut (.aclk(aclk), .areset(areset), .bus(bus2), .o_short_cnt(short_cnt2));

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic [1:0]  rdy;
        logic        e_srdy;
        logic [1:0]  e_mv;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic        e_last;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct packed {
        logic [1:0][31:0] d;
        logic             last;
    } grp_t;

    vec_t        vecs [16];
    grp_t        exp_q [$];
    logic [31:0] part [2];
    int          part_n = 0;
    int          pads = 0;
    logic [1:0]  retired = '0;
    logic [1:0]  prev_mv = '0;
    logic [1:0]  prev_rdy = '0;
    int          total = 0;
    int          bad = 0;

    function automatic vec_t mk(bit v, int d, bit l, bit [1:0] r, bit es, bit [1:0] em,
                                int d0, int d1, bit el, int c);
        vec_t x;
        x.v = v; x.d = 32'(d); x.l = l; x.rdy = r; x.e_srdy = es; x.e_mv = em;
        x.e_d0 = 32'(d0); x.e_d1 = 32'(d1); x.e_last = el; x.e_cnt = 16'(c);
        return x;
    endfunction

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic l, input logic [1:0] rdy);
        bus.s_tvalid = v;
        bus.s_tdata  = W'(d);
        bus.s_tlast  = l;
        bus.m_tready = rdy;
    endtask

    // Scoreboard view of one sample: every valid lane must show the head group.
    task monitor_lanes;
        logic [1:0] mv;
        mv = bus.m_tvalid;
        for (int i = 0; i < N; i++) begin
            if (prev_mv[i] && !prev_rdy[i]) check_output("rand_hold_valid", W'(mv[i]), W'(1));
        end
        if (mv != 2'b00) begin
            if (exp_q.size() == 0) begin
                check_output("rand_unexpected_group", W'(mv), W'(0));
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (mv[i]) begin
                        check_output("rand_lane_retired_twice", W'(retired[i]), W'(0));
                        check_output("rand_lane_data", bus.m_tdata[i], W'(exp_q[0].d[i]));
                    end
                end
                check_output("rand_last", W'(bus.m_tlast), W'(exp_q[0].last));
                for (int i = 0; i < N; i++) begin
                    if (mv[i] && bus.m_tready[i]) retired[i] = 1'b1;
                end
                if (retired == 2'b11) begin
                    void'(exp_q.pop_front());
                    retired = '0;
                end
            end
        end
        prev_mv  = mv;
        prev_rdy = bus.m_tready;
    endtask

    task model_accept(input logic [31:0] d, input logic l);
        grp_t g;
        part[part_n] = d;
        part_n++;
        if (part_n == N || l) begin
            g.d[0] = part[0];
            g.d[1] = (part_n == N) ? part[1] : 32'd1;
            if (part_n < N) pads++;
            g.last = l;
            exp_q.push_back(g);
            part_n = 0;
        end
    endtask

    initial begin
        int acc;
        int cyc;
        int exp_c;

        apply_stimulus(1'b0, 32'd0, 1'b0, 2'b11);
        bus2.s_tvalid = 1'b0; bus2.s_tdata = '0; bus2.s_tlast = 1'b0; bus2.m_tready = 2'b11;

        vecs[0]  = mk(1, 10,  0, 2'b11, 1, 2'b00, 0,   0,   0, 0);
        vecs[1]  = mk(1, 20,  0, 2'b11, 1, 2'b11, 10,  20,  0, 0);
        vecs[2]  = mk(1, 30,  0, 2'b11, 1, 2'b00, 0,   0,   0, 0);
        vecs[3]  = mk(1, 40,  1, 2'b11, 1, 2'b11, 30,  40,  1, 0);
        vecs[4]  = mk(1, 5,   0, 2'b11, 1, 2'b00, 0,   0,   0, 0);
        vecs[5]  = mk(1, 6,   0, 2'b11, 1, 2'b11, 5,   6,   0, 0);
        vecs[6]  = mk(1, 7,   1, 2'b11, 1, 2'b00, 0,   0,   0, 0);
        vecs[7]  = mk(0, 0,   0, 2'b11, 0, 2'b11, 7,   1,   1, 1);
        vecs[8]  = mk(0, 0,   0, 2'b11, 1, 2'b00, 0,   0,   0, 1);
        vecs[9]  = mk(1, 100, 0, 2'b00, 1, 2'b00, 0,   0,   0, 1);
        vecs[10] = mk(1, 101, 0, 2'b00, 1, 2'b11, 100, 101, 0, 1);
        vecs[11] = mk(1, 102, 0, 2'b01, 1, 2'b10, 100, 101, 0, 1);
        vecs[12] = mk(1, 103, 0, 2'b01, 0, 2'b10, 100, 101, 0, 1);
        vecs[13] = mk(1, 103, 0, 2'b01, 0, 2'b10, 100, 101, 0, 1);
        vecs[14] = mk(1, 103, 0, 2'b10, 1, 2'b11, 102, 103, 0, 1);
        vecs[15] = mk(0, 0,   0, 2'b11, 1, 2'b00, 0,   0,   0, 1);

        #12;
        check_output("rst_m_tvalid", W'(bus.m_tvalid), W'(0));
        check_output("rst_m_tlast", W'(bus.m_tlast), W'(0));
        check_output("rst_m_tdata0", bus.m_tdata[0], W'(0));
        check_output("rst_m_tdata1", bus.m_tdata[1], W'(0));
        check_output("rst_s_tready", W'(bus.s_tready), W'(0));
        check_output("rst_short_cnt", W'(short_cnt), W'(0));
        @(negedge aclk);
        areset = 1'b1;
        @(posedge aclk); #1;
        check_output("rel_s_tready", W'(bus.s_tready), W'(1));

        for (int i = 0; i < 16; i++) begin
            @(negedge aclk);
            apply_stimulus(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].rdy);
            #1;
            check_output($sformatf("v%0d_s_tready", i), W'(bus.s_tready), W'(vecs[i].e_srdy));
            @(posedge aclk); #1;
            check_output($sformatf("v%0d_m_tvalid", i), W'(bus.m_tvalid), W'(vecs[i].e_mv));
            if (vecs[i].e_mv[0]) check_output($sformatf("v%0d_lane0", i), bus.m_tdata[0], W'(vecs[i].e_d0));
            if (vecs[i].e_mv[1]) check_output($sformatf("v%0d_lane1", i), bus.m_tdata[1], W'(vecs[i].e_d1));
            if (vecs[i].e_mv != 2'b00) check_output($sformatf("v%0d_m_tlast", i), W'(bus.m_tlast), W'(vecs[i].e_last));
            check_output($sformatf("v%0d_short_cnt", i), W'(short_cnt), W'(vecs[i].e_cnt));
        end

        // Reset with a loaded bank and one staged beat, then a fresh group must form.
        @(negedge aclk); apply_stimulus(1'b1, 32'd60, 1'b0, 2'b00);
        @(negedge aclk); apply_stimulus(1'b1, 32'd61, 1'b0, 2'b00);
        @(negedge aclk); apply_stimulus(1'b1, 32'd62, 1'b0, 2'b00);
        @(posedge aclk); #2;
        check_output("pre_rst_m_tvalid", W'(bus.m_tvalid), W'(2'b11));
        apply_stimulus(1'b0, 32'd0, 1'b0, 2'b00);
        areset = 1'b0;
        #1;
        check_output("async_rst_m_tvalid", W'(bus.m_tvalid), W'(0));
        check_output("async_rst_m_tlast", W'(bus.m_tlast), W'(0));
        check_output("async_rst_s_tready", W'(bus.s_tready), W'(0));
        check_output("async_rst_short_cnt", W'(short_cnt), W'(0));
        @(negedge aclk); areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk); apply_stimulus(1'b1, 32'd11, 1'b0, 2'b11);
        #1;
        check_output("post_rst_s_tready", W'(bus.s_tready), W'(1));
        @(posedge aclk); #1;
        check_output("post_rst_first_beat", W'(bus.m_tvalid), W'(0));
        @(negedge aclk); apply_stimulus(1'b1, 32'd22, 1'b0, 2'b11);
        @(posedge aclk); #1;
        check_output("post_rst_m_tvalid", W'(bus.m_tvalid), W'(2'b11));
        check_output("post_rst_lane0", bus.m_tdata[0], W'(11));
        check_output("post_rst_lane1", bus.m_tdata[1], W'(22));
        @(negedge aclk); apply_stimulus(1'b0, 32'd0, 1'b0, 2'b11);

        // Random backpressure against the scoreboard, starting from a clean reset.
        @(negedge aclk); areset = 1'b0;
        @(negedge aclk); areset = 1'b1;
        @(posedge aclk);
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            @(negedge aclk);
            cyc++;
            apply_stimulus($urandom_range(3) != 0, $urandom, (acc == 999) || ($urandom_range(3) == 0),
                           2'($urandom_range(3)));
            #1;
            monitor_lanes();
            if (bus.s_tvalid && bus.s_tready) begin
                model_accept(bus.s_tdata[31:0], bus.s_tlast);
                acc++;
            end
        end
        check_output("rand_beats_accepted", W'(acc), W'(1000));
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            apply_stimulus(1'b0, 32'd0, 1'b0, 2'b11);
            #1;
            monitor_lanes();
        end
        check_output("rand_groups_drained", W'(exp_q.size()), W'(0));
        check_output("rand_partial_left", W'(part_n), W'(0));
        check_output("rand_pad_count", W'(short_cnt), W'(pads));

        // Single-beat packets on the 2-bit counter instance.
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            bus2.s_tvalid = 1'b1; bus2.s_tdata = W'(200 + k); bus2.s_tlast = 1'b1;
            #1;
            check_output($sformatf("sat%0d_s_tready", k), W'(bus2.s_tready), W'(1));
            @(negedge aclk);
            bus2.s_tvalid = 1'b0; bus2.s_tlast = 1'b0;
            #1;
            check_output($sformatf("sat%0d_pad_stall", k), W'(bus2.s_tready), W'(0));
            @(posedge aclk); #1;
            exp_c = (k + 1 > 3) ? 3 : k + 1;
            check_output($sformatf("sat%0d_m_tvalid", k), W'(bus2.m_tvalid), W'(2'b11));
            check_output($sformatf("sat%0d_lane0", k), bus2.m_tdata[0], W'(200 + k));
            check_output($sformatf("sat%0d_lane1_pad", k), bus2.m_tdata[1], W'(1));
            check_output($sformatf("sat%0d_m_tlast", k), W'(bus2.m_tlast), W'(1));
            check_output($sformatf("sat%0d_short_cnt", k), W'(short_cnt2), W'(exp_c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
